pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order core pipeline. It merges memory-hierarchy busy signals, load-use hazards and taken-branch redirects into per-stage enable and flush strobes. These strobes drive the IF/ID, ID/EX and EX/MEM registers and the PC. It holds a branch redirect that arrives during a memory stall until the stall releases, and it keeps saturating stall and flush statistics counters.

Parameters:
RW, 5, register-index width
CW, 16, width of statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
icache_busy  in  1  L1 I-side not ready
dcache_busy  in  1  L1 D-side not ready
id_rs1  in  RW  source reg 1 of instruction in ID
id_rs2  in  RW  source reg 2 of instruction in ID
ex_rd  in  RW  destination reg of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump (one-cycle pulse)
stat_clear  in  1  synchronous clear of statistics counters
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID clock enable
ifid_flush  out  1  IF/ID loads NOP (0x00000013)
idex_en  out  1  ID/EX clock enable
idex_flush  out  1  ID/EX loads bubble
exmem_en  out  1  EX/MEM clock enable
pipe_state  out  2  FSM state: 0 RUN, 1 MEM_STALL, 2 LU_STALL, 3 REDIRECT
stall_count  out  CW  saturating count of cycles with pc_en=0
flush_count  out  CW  saturating count of redirects applied

Behaviour:
- Reset (async, active-high): state=RUN, redirect_pend=0, stall_count=0, flush_count=0. The combinational outputs then give pc_en=1, ifid_en=1, idex_en=1, exmem_en=1, ifid_flush=0, idex_flush=0.
- Internal terms:
  - mem_stall = icache_busy | dcache_busy.
  - load_use = ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - redirect = ex_branch_taken | redirect_pend.
- Outputs (combinational from inputs and registered state):
  - exmem_en = idex_en = ~mem_stall.
  - pc_en = ~mem_stall & (redirect | ~load_use).
  - ifid_en = pc_en.
  - ifid_flush = ~mem_stall & redirect.
  - idex_flush = ~mem_stall & (redirect | load_use).
- Priority: mem_stall > redirect > load_use. A redirect squashes the hazarding instruction, so no load-use stall is taken in the same cycle.
- redirect_pend register:
  - Set on the clock edge where ex_branch_taken & mem_stall.
  - Cleared on the first edge with ~mem_stall.
  - Set and clear in the same cycle cannot occur by construction.
- FSM, next state evaluated each edge in priority order:
  - mem_stall -> MEM_STALL.
  - else redirect -> REDIRECT.
  - else load_use -> LU_STALL.
  - else RUN.
  - pipe_state shows the registered state, i.e. the cause of the previous cycle's action. Observability only; outputs do not depend on it.
- stall_count: +1 on each edge where pc_en=0, saturating at 2^CW-1.
- flush_count: +1 on each edge where ifid_flush=1, saturating.
- stat_clear: zeroes both counters and has priority over increment. FSM and redirect_pend are unaffected.
- Latency: hazard response is same-cycle (zero-cycle). A pending redirect is applied on the first non-stalled cycle.
- Reset mid-stall drops any pending redirect.

Test Plan:
1. Reset asserted mid-operation with redirect_pend=1 -> all enables=1, flushes=0, pipe_state=0, counters=0 immediately, without waiting for a clock edge.
2. ex_mem_read=1, ex_rd=5, id_rs1=5, no busy -> pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; next state LU_STALL; stall_count=1. Repeat with ex_rd=0 -> no stall.
3. ex_branch_taken pulse with load_use also true -> ifid_flush=1, idex_flush=1, pc_en=1; flush_count=1; state REDIRECT.
4. dcache_busy high 3 cycles, ex_branch_taken pulsed in cycle 1 -> all enables 0 and flushes 0 for 3 cycles. On the cycle busy drops: ifid_flush=1, idex_flush=1, pc_en=1, flush_count=1, stall_count=3.
5. Force stall_count to 2^CW-1 using a small CW=3 instance with 9 stall cycles -> holds at 7. Pulse stat_clear together with a stall cycle -> counter=0.
6. icache_busy with id/ex hazard fields toggling randomly -> exmem_en=idex_en=pc_en=0, no flush, for every busy cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline: merges memory busy,
// load-use hazards and branch redirects into per-stage enable/flush strobes.
module pipe_hazard_ctrl #(
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          icache_busy,
   input  logic          dcache_busy,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic [RW-1:0] ex_rd,
   input  logic          ex_mem_read,
   input  logic          ex_branch_taken,
   input  logic          stat_clear,
   output logic          pc_en,
   output logic          ifid_en,
   output logic          ifid_flush,
   output logic          idex_en,
   output logic          idex_flush,
   output logic          exmem_en,
   output logic [1:0]    pipe_state,
   output logic [CW-1:0] stall_count,
   output logic [CW-1:0] flush_count
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MEM_STALL = 2'd1,
      LU_STALL  = 2'd2,
      REDIRECT  = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_r;
   state_t        state_nxt_s;
   logic          redirect_pend_r;
   logic          redirect_pend_nxt_s;
   logic [CW-1:0] stall_count_r;
   logic [CW-1:0] flush_count_r;
   logic          mem_stall_s;
   logic          load_use_s;
   logic          redirect_s;
   logic          pc_en_s;
   logic          ifid_flush_s;
   logic          idex_flush_s;

   assign mem_stall_s  = icache_busy | dcache_busy;
   assign load_use_s   = ex_mem_read & (ex_rd != {RW{1'b0}}) &
                         ((ex_rd == id_rs1) | (ex_rd == id_rs2));
   assign redirect_s   = ex_branch_taken | redirect_pend_r;

   // A redirect squashes the hazarding instruction, so it overrides load-use.
   assign pc_en_s      = ~mem_stall_s & (redirect_s | ~load_use_s);
   assign ifid_flush_s = ~mem_stall_s & redirect_s;
   assign idex_flush_s = ~mem_stall_s & (redirect_s | load_use_s);

   assign pc_en        = pc_en_s;
   assign ifid_en      = pc_en_s;
   assign ifid_flush   = ifid_flush_s;
   assign idex_en      = ~mem_stall_s;
   assign exmem_en     = ~mem_stall_s;
   assign idex_flush   = idex_flush_s;
   assign pipe_state   = state_r;
   assign stall_count  = stall_count_r;
   assign flush_count  = flush_count_r;

   // Next-state and pending-redirect decode in mem_stall > redirect > load_use order.
   always_comb begin
      state_nxt_s         = RUN;
      redirect_pend_nxt_s = 1'b0;
      if (mem_stall_s) begin
         state_nxt_s         = MEM_STALL;
         redirect_pend_nxt_s = redirect_pend_r | ex_branch_taken;
      end else if (redirect_s) begin
         state_nxt_s = REDIRECT;
      end else if (load_use_s) begin
         state_nxt_s = LU_STALL;
      end else begin
         state_nxt_s = RUN;
      end
   end

   // State and pending-redirect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= RUN;
         redirect_pend_r <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         redirect_pend_r <= redirect_pend_nxt_s;
      end
   end

   // Saturating statistics counters; stat_clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_r <= {CW{1'b0}};
         flush_count_r <= {CW{1'b0}};
      end else if (stat_clear) begin
         stall_count_r <= {CW{1'b0}};
         flush_count_r <= {CW{1'b0}};
      end else begin
         if (!pc_en_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
         end else begin
            stall_count_r <= stall_count_r;
         end
         if (ifid_flush_s && (flush_count_r != CNT_MAX)) begin
            flush_count_r <= flush_count_r + CNT_ONE;
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a CW=16 and a CW=3 instance share stimulus
// and are compared against a rule-level reference model each cycle.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       icache_busy = 1'b0, dcache_busy = 1'b0;
   logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
   logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, stat_clear = 1'b0;

   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
   logic [1:0]  pipe_state;
   logic [15:0] stall_count, flush_count;
   logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en;
   logic [1:0]  s_pipe_state;
   logic [2:0]  s_stall_count, s_flush_count;

   pipe_hazard_ctrl #(.RW(5), .CW(16)) dut (
      .clk(clk), .reset(reset), .icache_busy(icache_busy), .dcache_busy(dcache_busy),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .stat_clear(stat_clear),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .pipe_state(pipe_state),
      .stall_count(stall_count), .flush_count(flush_count));

   pipe_hazard_ctrl #(.RW(5), .CW(3)) dut_small (
      .clk(clk), .reset(reset), .icache_busy(icache_busy), .dcache_busy(dcache_busy),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .stat_clear(stat_clear),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
      .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .pipe_state(s_pipe_state),
      .stall_count(s_stall_count), .flush_count(s_flush_count));

   always #5 clk = ~clk;

   typedef struct {
      int pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, st, sc, fc, sc3, fc3;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state: cause of last cycle, pending redirect, counters
   int m_state = 0, m_pend = 0, m_sc = 0, m_fc = 0, m_sc3 = 0, m_fc3 = 0;

   task automatic chk(input string nm, input string tag, input logic [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%s] t=%0t: got %0d expected %0d", nm, tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pend = 0; m_sc = 0; m_fc = 0; m_sc3 = 0; m_fc3 = 0;
   endtask

   function automatic exp_t predict(input bit ic, dc, input int rs1, rs2, rd,
                                    input bit mr, bt, input string tag);
      exp_t e;
      bit mem, lu, br;
      mem = ic || dc;
      lu  = mr && rd != 0 && (rd == rs1 || rd == rs2);
      br  = bt || (m_pend != 0);
      e.tag = tag;
      e.st = m_state; e.sc = m_sc; e.fc = m_fc; e.sc3 = m_sc3; e.fc3 = m_fc3;
      if (mem) begin
         e.pc = 0; e.idex_en = 0; e.exmem = 0; e.ifid_fl = 0; e.idex_fl = 0;
      end else if (br) begin
         e.pc = 1; e.idex_en = 1; e.exmem = 1; e.ifid_fl = 1; e.idex_fl = 1;
      end else if (lu) begin
         e.pc = 0; e.idex_en = 1; e.exmem = 1; e.ifid_fl = 0; e.idex_fl = 1;
      end else begin
         e.pc = 1; e.idex_en = 1; e.exmem = 1; e.ifid_fl = 0; e.idex_fl = 0;
      end
      e.ifid_en = e.pc;
      return e;
   endfunction

   task automatic model_step(input bit ic, dc, input int rs1, rs2, rd,
                             input bit mr, bt, clr, input exp_t e);
      bit mem, lu, br;
      mem = ic || dc;
      lu  = mr && rd != 0 && (rd == rs1 || rd == rs2);
      br  = bt || (m_pend != 0);
      m_state = mem ? 1 : br ? 3 : lu ? 2 : 0;
      m_pend  = mem ? int'(m_pend != 0 || bt) : 0;
      if (clr) begin
         m_sc = 0; m_fc = 0; m_sc3 = 0; m_fc3 = 0;
      end else begin
         if (e.pc == 0)  begin m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc; m_sc3 = (m_sc3 < 7) ? m_sc3 + 1 : m_sc3; end
         if (e.ifid_fl)  begin m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc; m_fc3 = (m_fc3 < 7) ? m_fc3 + 1 : m_fc3; end
      end
   endtask

   task automatic cyc(input bit ic, dc, input int rs1, rs2, rd,
                      input bit mr, bt, clr, input string tag);
      exp_t e;
      @(posedge clk); #1;
      reset = 1'b0;
      icache_busy = ic; dcache_busy = dc;
      id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); ex_rd = 5'(rd);
      ex_mem_read = mr; ex_branch_taken = bt; stat_clear = clr;
      e = predict(ic, dc, rs1, rs2, rd, mr, bt, tag);
      exp_q.push_back(e);
      model_step(ic, dc, rs1, rs2, rd, mr, bt, clr, e);
   endtask

   // reset asserted between edges; outputs are checked before the next edge
   task automatic do_reset(input string tag);
      exp_t e;
      @(posedge clk); #1;
      icache_busy = 1'b0; dcache_busy = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; stat_clear = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      #1 reset = 1'b1;
      model_reset();
      e = predict(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, tag);
      exp_q.push_back(e);
   endtask

   // monitor: compares every presented cycle against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_en", e.tag, 32'(pc_en), e.pc);
            chk("ifid_en", e.tag, 32'(ifid_en), e.ifid_en);
            chk("ifid_flush", e.tag, 32'(ifid_flush), e.ifid_fl);
            chk("idex_en", e.tag, 32'(idex_en), e.idex_en);
            chk("idex_flush", e.tag, 32'(idex_flush), e.idex_fl);
            chk("exmem_en", e.tag, 32'(exmem_en), e.exmem);
            chk("pipe_state", e.tag, 32'(pipe_state), e.st);
            chk("stall_count", e.tag, 32'(stall_count), e.sc);
            chk("flush_count", e.tag, 32'(flush_count), e.fc);
            chk("s_pc_en", e.tag, 32'(s_pc_en), e.pc);
            chk("s_ifid_en", e.tag, 32'(s_ifid_en), e.ifid_en);
            chk("s_ifid_flush", e.tag, 32'(s_ifid_flush), e.ifid_fl);
            chk("s_idex_en", e.tag, 32'(s_idex_en), e.idex_en);
            chk("s_idex_flush", e.tag, 32'(s_idex_flush), e.idex_fl);
            chk("s_exmem_en", e.tag, 32'(s_exmem_en), e.exmem);
            chk("s_pipe_state", e.tag, 32'(s_pipe_state), e.st);
            chk("s_stall_count", e.tag, 32'(s_stall_count), e.sc3);
            chk("s_flush_count", e.tag, 32'(s_flush_count), e.fc3);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset("init");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "idle");
      // load-use on rs1, then the same with rd=0
      cyc(0, 0, 5, 7, 5, 1, 0, 0, "lu_rs1");
      cyc(0, 0, 5, 7, 5, 1, 0, 0, "lu_rs1_b");
      cyc(0, 0, 0, 0, 0, 1, 0, 0, "lu_rd0");
      cyc(0, 0, 3, 9, 9, 1, 0, 0, "lu_rs2");
      // branch together with load-use: redirect wins
      cyc(0, 0, 5, 7, 5, 1, 1, 0, "br_lu");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "after_br");
      // dcache busy 3 cycles with branch in the first; redirect applied on release
      cyc(0, 1, 1, 2, 3, 0, 1, 0, "busy1_br");
      cyc(0, 1, 5, 2, 5, 1, 0, 0, "busy2");
      cyc(0, 1, 1, 2, 3, 0, 0, 0, "busy3");
      cyc(0, 0, 5, 2, 5, 1, 0, 0, "release");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "post_release");
      // small instance saturation: 9 stall cycles, then clear during a stall
      for (int i = 0; i < 9; i++) cyc(1, 0, 1, 2, 3, 0, 0, 0, "sat");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "sat_hold");
      cyc(0, 1, 1, 2, 3, 0, 0, 1, "clr_stall");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "after_clr");
      // reset mid-stall with a redirect pending drops it
      cyc(0, 1, 1, 2, 3, 0, 1, 0, "pend_set");
      cyc(0, 1, 1, 2, 3, 0, 0, 0, "pend_hold");
      do_reset("reset_pend");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "pend_dropped");
      // icache busy with random hazard fields
      for (int i = 0; i < 12; i++)
         cyc(1, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), 0, "ic_busy");
      cyc(0, 0, 1, 2, 3, 0, 0, 0, "ic_release");
      // random mix
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 5) == 0,
             $urandom_range(0, 40) == 0, "rand");
      repeat (2) @(posedge clk);
      chk("queue_drained", "end", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
